// File: rtl/fp_add_pkg.sv
// Shared definitions for the half-precision serial adder sequencer.
//   - state_e      : controller FSM states (3-bit encoding)
//   - FP_WIDTH     : default operand/result width
//   - EXP_* / MAN_*: half-precision field positions used by the optional NaN flag
//   - is_half_nan  : exponent all ones with a non-zero mantissa
package fp_add_pkg;

  localparam int unsigned FP_WIDTH = 16;

  localparam int unsigned EXP_MSB = 14;
  localparam int unsigned EXP_LSB = 10;
  localparam int unsigned MAN_MSB = 9;
  localparam logic [4:0]  EXP_ALL_ONES = 5'h1F;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StLatch,
    StAddStart,
    StWaitDone,
    StShiftOut
  } state_e;

  // Infinity (zero mantissa) is deliberately not a NaN.
  function automatic logic is_half_nan(input logic [FP_WIDTH-1:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (v[MAN_MSB:0] != '0);
  endfunction

endpackage

// File: rtl/fp_add_ctrl_if.sv
// Handshake/bus bundle between the serial host link, the shift-register/adder
// datapath and the fp_add_ctrl sequencer.
//   slave  : the sequencer's view (host/datapath inputs in, strobes and results out)
//   master : the environment's view (host link, adder, downstream sink)
// Optional macro FP_ADD_CTRL_NAN_FLAG_EN adds the nan_out flag.
interface fp_add_ctrl_if
  import fp_add_pkg::*;
#(
  parameter int unsigned WIDTH = FP_WIDTH
);

  logic             start_in;
  logic             serial_in;
  logic             in_valid_in;
  logic             in_ready_out;
  logic             sr_wr_a_out;
  logic             sr_wr_b_out;
  logic             sr_data_out;
  logic             sr_en_out;
  logic             add_start_out;
  logic             add_done_in;
  logic [WIDTH-1:0] result_in;
  logic             serial_out;
  logic             out_valid_out;
  logic             out_ready_in;
  logic             busy_out;
  logic             done_out;
  logic             err_out;
`ifdef FP_ADD_CTRL_NAN_FLAG_EN
  logic             nan_out;

  modport slave (
    input  start_in, serial_in, in_valid_in, add_done_in, result_in, out_ready_in,
    output in_ready_out, sr_wr_a_out, sr_wr_b_out, sr_data_out, sr_en_out, add_start_out,
    output serial_out, out_valid_out, busy_out, done_out, err_out, nan_out
  );

  modport master (
    output start_in, serial_in, in_valid_in, add_done_in, result_in, out_ready_in,
    input  in_ready_out, sr_wr_a_out, sr_wr_b_out, sr_data_out, sr_en_out, add_start_out,
    input  serial_out, out_valid_out, busy_out, done_out, err_out, nan_out
  );
`else
  modport slave (
    input  start_in, serial_in, in_valid_in, add_done_in, result_in, out_ready_in,
    output in_ready_out, sr_wr_a_out, sr_wr_b_out, sr_data_out, sr_en_out, add_start_out,
    output serial_out, out_valid_out, busy_out, done_out, err_out
  );

  modport master (
    output start_in, serial_in, in_valid_in, add_done_in, result_in, out_ready_in,
    input  in_ready_out, sr_wr_a_out, sr_wr_b_out, sr_data_out, sr_en_out, add_start_out,
    input  serial_out, out_valid_out, busy_out, done_out, err_out
  );
`endif

endinterface

// File: rtl/fp_ser_out.sv
// Result serializer: captures the adder sum, then shifts it out LSB first under
// a valid/ready handshake.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   capture          : load data into the shift register and clear the bit counter
//   data             : adder sum to capture
//   active           : controller is in its shift-out state
//   ready            : downstream accepts the current bit
//   serial, valid    : current result bit and its qualifier
//   last             : final bit is being accepted this cycle (tells the FSM to finish)
//   done             : registered one-cycle pulse after the final bit was accepted
module fp_ser_out #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             capture,
  input  logic [WIDTH-1:0] data,
  input  logic             active,
  input  logic             ready,
  output logic             serial,
  output logic             valid,
  output logic             last,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] res_q;
  logic [CntW-1:0]  cnt_q;
  logic             done_q;
  logic             accept;

  assign valid  = active;
  // Gated so the line stays low outside the shift-out phase.
  assign serial = active & res_q[0];
  assign accept = active & ready;
  assign last   = accept && (cnt_q == CntLast);
  assign done   = done_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      res_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (capture) begin
        res_q <= data;
        cnt_q <= '0;
      end else if (accept) begin
        res_q <= res_q >> 1;
        cnt_q <= last ? '0 : cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_ctrl.sv
// Sequencer for the half-precision serial adder path: streams operand A then B
// (LSB first) into the shift registers, enables their parallel outputs, pulses
// the adder start, waits for completion with a timeout, then serializes the sum.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   bus (slave)      : host serial link, shift-register strobes, adder handshake,
//                      result serial link, busy/done/err status
// Parameters: WIDTH (operand width), ADD_TIMEOUT (WAIT_DONE cycle limit, >= 2).
// Optional macro FP_ADD_CTRL_NAN_FLAG_EN adds bus.nan_out (requires WIDTH == 16).
module fp_add_ctrl
  import fp_add_pkg::*;
#(
  parameter int unsigned WIDTH       = FP_WIDTH,
  parameter int unsigned ADD_TIMEOUT = 64
) (
  input logic          clk_in,
  input logic          rst_n_in,
  fp_add_ctrl_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ToW  = $clog2(ADD_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(ADD_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  logic capture;
  logic ser_last;
  logic ser_serial;
  logic ser_valid;
  logic ser_done;
  logic in_ready;
  logic sr_wr_a;
  logic sr_wr_b;
  logic sr_data;
  logic sr_en;
  logic add_start;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    capture   = 1'b0;
    in_ready  = 1'b0;
    sr_wr_a   = 1'b0;
    sr_wr_b   = 1'b0;
    sr_data   = 1'b0;
    sr_en     = 1'b0;
    add_start = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start_in) begin
          err_d     = 1'b0;
          bit_cnt_d = '0;
          state_d   = StLoadA;
        end
      end

      StLoadA, StLoadB: begin
        in_ready = 1'b1;
        sr_data  = bus.serial_in;
        sr_wr_a  = (state_q == StLoadA) & bus.in_valid_in;
        sr_wr_b  = (state_q == StLoadB) & bus.in_valid_in;
        if (bus.in_valid_in) begin
          if (bit_cnt_q == CntLast) begin
            bit_cnt_d = '0;
            state_d   = (state_q == StLoadA) ? StLoadB : StLatch;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      StLatch: begin
        sr_en   = 1'b1;
        state_d = StAddStart;
      end

      StAddStart: begin
        sr_en     = 1'b1;
        add_start = 1'b1;
        to_cnt_d  = '0;
        state_d   = StWaitDone;
      end

      StWaitDone: begin
        sr_en    = 1'b1;
        to_cnt_d = to_cnt_q + 1'b1;
        // A completion arriving on the final allowed cycle still counts.
        if (bus.add_done_in) begin
          capture = 1'b1;
          state_d = StShiftOut;
        end else if (to_cnt_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end

      StShiftOut: begin
        if (ser_last) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
    end
  end

  fp_ser_out #(
    .WIDTH(WIDTH)
  ) u_ser_out (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .capture (capture),
    .data    (bus.result_in),
    .active  (state_q == StShiftOut),
    .ready   (bus.out_ready_in),
    .serial  (ser_serial),
    .valid   (ser_valid),
    .last    (ser_last),
    .done    (ser_done)
  );

  assign bus.in_ready_out  = in_ready;
  assign bus.sr_wr_a_out   = sr_wr_a;
  assign bus.sr_wr_b_out   = sr_wr_b;
  assign bus.sr_data_out   = sr_data;
  assign bus.sr_en_out     = sr_en;
  assign bus.add_start_out = add_start;
  assign bus.serial_out    = ser_serial;
  assign bus.out_valid_out = ser_valid;
  assign bus.busy_out      = (state_q != StIdle);
  assign bus.done_out      = ser_done;
  assign bus.err_out       = err_q;

`ifdef FP_ADD_CTRL_NAN_FLAG_EN
  logic nan_q;

  // Flag reflects the most recent captured sum until the next transaction starts.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      nan_q <= 1'b0;
    end else if ((state_q == StIdle) && bus.start_in) begin
      nan_q <= 1'b0;
    end else if (capture) begin
      nan_q <= is_half_nan(bus.result_in[FP_WIDTH-1:0]);
    end
  end

  assign bus.nan_out = nan_q;
`endif

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Self-checking bench for fp_add_ctrl: directed transactions, an adder stub, and
// a per-cycle scoreboard that predicts operand strobes and result bits from the
// operands/sum of the current transaction.
module tb_fp_add_ctrl;

  localparam int W  = 16;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  fp_add_ctrl_if #(.WIDTH(W)) bus ();

  fp_add_ctrl #(
    .WIDTH      (W),
    .ADD_TIMEOUT(TO)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state for the current transaction.
  logic [W-1:0] cur_a, cur_b, a_word, b_word, out_word, stub_res;
  bit           stub_en;
  int a_idx, b_idx, out_idx, load_a_cyc, load_b_cyc;
  int add_start_cnt, add_start_cyc, done_cnt, out_valid_cnt, first_valid_cyc, start_cyc;
  int err_at_load;
  logic exp_q[$];
  bit   hold_prev;
  logic prev_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] all_outs();
    return {bus.in_ready_out, bus.sr_wr_a_out, bus.sr_wr_b_out, bus.sr_data_out,
            bus.sr_en_out, bus.add_start_out, bus.serial_out, bus.out_valid_out,
            bus.busy_out, bus.done_out, bus.err_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon(input logic [W-1:0] a, input logic [W-1:0] b);
    cur_a = a; cur_b = b; a_word = '0; b_word = '0; out_word = '0;
    a_idx = 0; b_idx = 0; out_idx = 0; load_a_cyc = 0; load_b_cyc = 0;
    add_start_cnt = 0; add_start_cyc = -1; done_cnt = 0; out_valid_cnt = 0;
    first_valid_cyc = -1; hold_prev = 0; exp_q.delete();
  endtask

  // Starts a transaction (DUT must be idle) and streams nbits of A then B.
  task automatic run_load(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit gaps, input int nbits);
    logic bv;
    clear_mon(a, b);
    bus.start_in = 1'b1;
    start_cyc = cyc;
    tick();
    bus.start_in = 1'b0;
    err_at_load = int'(bus.err_out);
    for (int i = 0; i < nbits; i++) begin
      bv = (i < W) ? a[i] : b[i-W];
      if (gaps) begin
        bus.in_valid_in = 1'b0;
        bus.serial_in   = ~bv;
        tick();
      end
      bus.in_valid_in = 1'b1;
      bus.serial_in   = bv;
      tick();
    end
    bus.in_valid_in = 1'b0;
    bus.serial_in   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    if (done_cnt == 0) check({name, "_done_timeout"}, 0, 1);
    tick();
  endtask

  // Adder stub: completes one cycle after the start pulse when enabled.
  initial begin
    bus.add_done_in = 1'b0;
    bus.result_in   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.add_start_out && stub_en) begin
        @(posedge clk);
        #1;
        bus.add_done_in = 1'b1;
        bus.result_in   = stub_res;
        for (int i = 0; i < W; i++) exp_q.push_back(stub_res[i]);
        @(posedge clk);
        #1;
        bus.add_done_in = 1'b0;
        bus.result_in   = ~stub_res;
      end
    end
  end

  // Per-cycle compare process.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.busy_out)
        check("idle_outs", {bus.in_ready_out, bus.sr_wr_a_out, bus.sr_wr_b_out,
                            bus.sr_en_out, bus.add_start_out, bus.out_valid_out}, 0);
      if (bus.sr_wr_a_out && bus.sr_wr_b_out) check("wr_both", 1, 0);
      if (bus.in_ready_out) begin
        if (a_idx < W) load_a_cyc++;
        else load_b_cyc++;
      end
      if (bus.sr_wr_a_out) begin
        if (a_idx < W) begin
          check("sr_data_a", bus.sr_data_out, cur_a[a_idx]);
          a_word[a_idx] = bus.sr_data_out;
        end else check("wr_a_extra", a_idx, W - 1);
        a_idx++;
      end
      if (bus.sr_wr_b_out) begin
        if (a_idx != W) check("wr_b_early", a_idx, W);
        if (b_idx < W) begin
          check("sr_data_b", bus.sr_data_out, cur_b[b_idx]);
          b_word[b_idx] = bus.sr_data_out;
        end else check("wr_b_extra", b_idx, W - 1);
        b_idx++;
      end
      if (bus.add_start_out) begin
        add_start_cnt++;
        add_start_cyc = cyc;
        check("sr_en_at_start", bus.sr_en_out, 1);
      end
      if (bus.out_valid_out) begin
        out_valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (hold_prev) check("serial_hold", bus.serial_out, prev_bit);
        if (bus.out_ready_in) begin
          if (exp_q.size() == 0) check("out_extra", out_idx, W);
          else check("serial_out", bus.serial_out, exp_q.pop_front());
          if (out_idx < W) out_word[out_idx] = bus.serial_out;
          out_idx++;
        end
        hold_prev = !bus.out_ready_in;
        prev_bit  = bus.serial_out;
      end else begin
        hold_prev = 0;
      end
      if (bus.done_out) begin
        done_cnt++;
        check("done_drain", exp_q.size(), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int err_cyc;
    bus.start_in     = 1'b0;
    bus.serial_in    = 1'b0;
    bus.in_valid_in  = 1'b0;
    bus.out_ready_in = 1'b1;
    stub_en  = 1'b1;
    stub_res = '0;
    clear_mon('0, '0);
    #1 rst_n = 1'b0;
    #2 check("reset_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", all_outs(), 0);

    // Nominal: 1.0 + 2.0 = 3.0
    stub_res = 16'h4200;
    run_load(16'h3C00, 16'h4000, 1'b0, 2 * W);
    wait_done("nom", 200);
    check("nom_wr_a", a_idx, 16);
    check("nom_wr_b", b_idx, 16);
    check("nom_a_bits", a_word, 16'h3C00);
    check("nom_b_bits", b_word, 16'h4000);
    check("nom_add_start", add_start_cnt, 1);
    check("nom_result", out_word, 16'h4200);
    check("nom_out_bits", out_idx, 16);
    check("nom_latency", first_valid_cyc - start_cyc, 36);
    check("nom_done", done_cnt, 1);
    check("nom_err", bus.err_out, 0);

    // Valid gaps every other cycle
    run_load(16'h3C00, 16'h4000, 1'b1, 2 * W);
    wait_done("gap", 300);
    check("gap_load_a_len", load_a_cyc, 32);
    check("gap_load_b_len", load_b_cyc, 32);
    check("gap_wr_a", a_idx, 16);
    check("gap_wr_b", b_idx, 16);
    check("gap_result", out_word, 16'h4200);

    // Output backpressure for 5 cycles after 6 bits
    stub_res = 16'hA5C3;
    run_load(16'h1234, 16'h00FF, 1'b0, 2 * W);
    for (int i = 0; i < 100 && out_idx < 6; i++) tick();
    check("bp_reached", out_idx, 6);
    bus.out_ready_in = 1'b0;
    repeat (5) tick();
    bus.out_ready_in = 1'b1;
    wait_done("bp", 100);
    check("bp_a_bits", a_word, 16'h1234);
    check("bp_result", out_word, 16'hA5C3);
    check("bp_out_bits", out_idx, 16);
    check("bp_valid_cycles", out_valid_cnt, 21);

    // Adder timeout
    stub_en = 1'b0;
    run_load(16'h3C00, 16'h4000, 1'b0, 2 * W);
    err_cyc = -1;
    for (int i = 0; i < 200 && !bus.err_out; i++) begin
      tick();
      if (bus.err_out) err_cyc = cyc;
    end
    check("to_err", bus.err_out, 1);
    check("to_cycles", err_cyc - add_start_cyc, 65);
    check("to_busy", bus.busy_out, 0);
    repeat (3) tick();
    check("to_sticky", bus.err_out, 1);
    check("to_no_valid", out_valid_cnt, 0);
    check("to_add_start", add_start_cnt, 1);
    stub_en  = 1'b1;
    stub_res = 16'h4200;
    run_load(16'h3C00, 16'h4000, 1'b0, 2 * W);
    check("to_err_cleared", err_at_load, 0);
    wait_done("to_next", 200);
    check("to_next_result", out_word, 16'h4200);

    // Reset during LOAD_B bit 7
    run_load(16'h3C00, 16'h4000, 1'b0, W + 7);
    bus.in_valid_in = 1'b1;
    bus.serial_in   = 1'b1;
    #3 rst_n = 1'b0;
    #1 check("rst_outs", all_outs(), 0);
    check("rst_b_partial", b_idx, 7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid_in = 1'b0;
    bus.serial_in   = 1'b0;
    tick();
    check("rst_idle", all_outs(), 0);
    repeat (5) tick();
    check("rst_no_valid", out_valid_cnt, 0);
    check("rst_no_add", add_start_cnt, 0);
    run_load(16'h3C00, 16'h4000, 1'b0, 2 * W);
    wait_done("rst_next", 200);
    check("rst_next_result", out_word, 16'h4200);
    check("rst_next_latency", first_valid_cyc - start_cyc, 36);

`ifdef FP_ADD_CTRL_NAN_FLAG_EN
    stub_res = 16'h7E00;
    run_load(16'h7E00, 16'h3C00, 1'b0, 2 * W);
    wait_done("nan", 200);
    check("nan_qnan", bus.nan_out, 1);
    stub_res = 16'h7C00;
    run_load(16'h7C00, 16'h3C00, 1'b0, 2 * W);
    wait_done("inf", 200);
    check("nan_inf", bus.nan_out, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
